// File: rtl/editor_mes_bcd.sv
// Month edit stage: loads the BCD month, steps it 01..12 from the buttons, strobes ACT.
// Optional hold-to-repeat stepping is enabled with `define AUTO_REPEAT_EN.
module editor_mes_bcd #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seleccion,
  input  logic [7:0] mes_rtc,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] dseg,
  output logic       ACT,
  output logic       edicion
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EDIT = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dseg_q, dseg_d;
  logic       act_q, act_d;
  logic       dir_q, dir_d;
  logic       btn_up_q, btn_down_q;
  logic       up_rise, dn_rise;
  logic       rep_fire;

  function automatic logic valid_bcd(input logic [7:0] v);
    return ((v[7:4] == 4'h0) && (v[3:0] >= 4'h1) && (v[3:0] <= 4'h9))
        || ((v[7:4] == 4'h1) && (v[3:0] <= 4'h2));
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    unique case (1'b1)
      (v == 8'h09): r = 8'h10;
      (v == 8'h12): r = 8'h01;
      default:      r = {v[7:4], v[3:0] + 4'd1};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    unique case (1'b1)
      (v == 8'h10): r = 8'h09;
      (v == 8'h01): r = 8'h12;
      default:      r = {v[7:4], v[3:0] - 4'd1};
    endcase
    return r;
  endfunction

  assign up_rise = btn_up & ~btn_up_q;
  assign dn_rise = btn_down & ~btn_down_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW = $clog2(RMAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lim;
  logic          rep_q, rep_d;
  logic          held;

  assign held = btn_up ^ btn_down;
  assign lim  = rep_q ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);

  // First extra step waits REPEAT_DELAY, later ones REPEAT_PERIOD
  always_comb begin
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!seleccion || state_q == IDLE || state_q == LOAD) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (state_q == EDIT) begin
      if (!held || up_rise || dn_rise) begin
        cnt_d = '0;
        rep_d = 1'b0;
      end else if ((cnt_q + 1'b1) >= lim) begin
        rep_fire = 1'b1;
        cnt_d    = '0;
        rep_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dseg_q     <= 8'h01;
      act_q      <= 1'b0;
      dir_q      <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
    end else begin
      dseg_q     <= dseg_d;
      act_q      <= act_d;
      dir_q      <= dir_d;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
    end
  end

  always_comb begin
    state_d = state_q;
    dseg_d  = dseg_q;
    act_d   = 1'b0;
    dir_d   = dir_q;
    if (!seleccion) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          dseg_d  = valid_bcd(mes_rtc) ? mes_rtc : 8'h01;
          state_d = EDIT;
        end
        EDIT: begin
          if (up_rise ^ dn_rise) begin
            dir_d   = dn_rise;
            state_d = UPD;
          end else if (rep_fire) begin
            dir_d   = btn_down;
            state_d = UPD;
          end
        end
        UPD: begin
          dseg_d  = dir_q ? bcd_dec(dseg_q) : bcd_inc(dseg_q);
          act_d   = 1'b1;
          state_d = EDIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dseg    = dseg_q;
    ACT     = act_q;
    edicion = (state_q != IDLE);
  end

endmodule

// File: tb/tb_editor_mes_bcd.sv
// Directed bench for editor_mes_bcd: load, BCD stepping, wrap, drops.
// Hold-to-repeat scenario runs only when built with AUTO_REPEAT_EN.
module tb_editor_mes_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic       seleccion;
  logic [7:0] mes_rtc;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] dseg;
  logic       ACT;
  logic       edicion;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  editor_mes_bcd #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .seleccion(seleccion),
    .mes_rtc  (mes_rtc),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .dseg     (dseg),
    .ACT      (ACT),
    .edicion  (edicion)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] m);
    seleccion = 1'b0;
    tick();
    mes_rtc   = m;
    seleccion = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    seleccion = 1'b0;
    mes_rtc   = 8'h00;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    tick();
    tick();
    total++;
    if (dseg !== 8'h01 || ACT !== 1'b0 || edicion !== 1'b0)
      $display("FAIL reset: dseg=%h ACT=%b edicion=%b want 01 0 0",
               dseg, ACT, edicion);
    else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_up();
    logic [7:0] exp [3];
    exp = '{8'h08, 8'h09, 8'h10};
    mes_rtc   = 8'h07;
    seleccion = 1'b1;
    tick();
    total++;
    if (edicion !== 1'b1 || dseg !== 8'h01)
      $display("FAIL load_state: edicion=%b dseg=%h want 1 01", edicion, dseg);
    else pass_cnt++;
    tick();
    total++;
    if (dseg !== 8'h07 || ACT !== 1'b0)
      $display("FAIL load_07: dseg=%h ACT=%b want 07 0", dseg, ACT);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      tick();
      total++;
      if (ACT !== 1'b0 || dseg !== ((i == 0) ? 8'h07 : exp[i-1]))
        $display("FAIL up_lat%0d: ACT=%b dseg=%h want 0 unchanged", i, ACT, dseg);
      else pass_cnt++;
      tick();
      total++;
      if (ACT !== 1'b1 || dseg !== exp[i])
        $display("FAIL up_step%0d: ACT=%b dseg=%h want 1 %h", i, ACT, dseg, exp[i]);
      else pass_cnt++;
      btn_up = 1'b0;
      tick();
      total++;
      if (ACT !== 1'b0)
        $display("FAIL up_actlow%0d: ACT=%b want 0", i, ACT);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    load(8'h12);
    total++;
    if (dseg !== 8'h12) $display("FAIL load_12: dseg=%h want 12", dseg);
    else pass_cnt++;
    btn_up = 1'b1;
    tick();
    tick();
    btn_up = 1'b0;
    total++;
    if (dseg !== 8'h01 || ACT !== 1'b1)
      $display("FAIL wrap_up: dseg=%h ACT=%b want 01 1", dseg, ACT);
    else pass_cnt++;
    tick();
    btn_down = 1'b1;
    tick();
    tick();
    btn_down = 1'b0;
    total++;
    if (dseg !== 8'h12 || ACT !== 1'b1)
      $display("FAIL wrap_down: dseg=%h ACT=%b want 12 1", dseg, ACT);
    else pass_cnt++;
    tick();
    load(8'h10);
    btn_down = 1'b1;
    tick();
    tick();
    btn_down = 1'b0;
    total++;
    if (dseg !== 8'h09) $display("FAIL dec_10: dseg=%h want 09", dseg);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_invalid();
    load(8'h1A);
    total++;
    if (dseg !== 8'h01 || ACT !== 1'b0 || edicion !== 1'b1)
      $display("FAIL invalid_1A: dseg=%h ACT=%b edicion=%b want 01 0 1",
               dseg, ACT, edicion);
    else pass_cnt++;
  endtask

  task automatic test_both();
    load(8'h05);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick();
    tick();
    total++;
    if (dseg !== 8'h05 || ACT !== 1'b0)
      $display("FAIL both_edges: dseg=%h ACT=%b want 05 0", dseg, ACT);
    else pass_cnt++;
    tick();
    total++;
    if (dseg !== 8'h05 || ACT !== 1'b0)
      $display("FAIL both_later: dseg=%h ACT=%b want 05 0", dseg, ACT);
    else pass_cnt++;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick();
  endtask

  task automatic test_drop_upd();
    load(8'h04);
    btn_up = 1'b1;
    tick();
    seleccion = 1'b0;
    tick();
    total++;
    if (ACT !== 1'b0 || edicion !== 1'b0 || dseg !== 8'h04)
      $display("FAIL drop_upd: ACT=%b edicion=%b dseg=%h want 0 0 04",
               ACT, edicion, dseg);
    else pass_cnt++;
    btn_up = 1'b0;
    tick();
    mes_rtc   = 8'h11;
    seleccion = 1'b1;
    tick();
    tick();
    total++;
    if (dseg !== 8'h11 || edicion !== 1'b1)
      $display("FAIL reload: dseg=%h edicion=%b want 11 1", dseg, edicion);
    else pass_cnt++;
  endtask

  task automatic test_idle_edge_dropped();
    seleccion = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    mes_rtc   = 8'h03;
    seleccion = 1'b1;
    tick();
    tick();
    tick();
    tick();
    total++;
    if (dseg !== 8'h03 || ACT !== 1'b0)
      $display("FAIL idle_edge: dseg=%h ACT=%b want 03 0", dseg, ACT);
    else pass_cnt++;
    btn_up = 1'b0;
    tick();
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_repeat();
    logic [7:0] exp [4];
    int         n;
    exp = '{8'h04, 8'h05, 8'h06, 8'h07};
    n   = 0;
    load(8'h03);
    btn_up = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      tick();
      if (ACT === 1'b1) begin
        total++;
        if (n >= 4 || dseg !== exp[n])
          $display("FAIL repeat_step%0d: dseg=%h at clk %0d", n, dseg, j);
        else pass_cnt++;
        n++;
      end
    end
    btn_up = 1'b0;
    tick();
    total++;
    if (n !== 4 || dseg !== 8'h07)
      $display("FAIL repeat_count: steps=%0d dseg=%h want 4 07", n, dseg);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_up();
    test_wrap();
    test_invalid();
    test_both();
    test_drop_upd();
    test_idle_edge_dropped();
`ifdef AUTO_REPEAT_EN
    test_repeat();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
